// File: rtl/six_adder_scheduler_pkg.sv
// Shared constants and helpers for the six-input adder scheduler.
package sched_pkg;

  localparam int ADD_LAT_DEFAULT = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // LSB of operand opnd (0 = A .. 5 = F) of requester req in the packed operand bus.
  function automatic int op_lsb(input int req, input int opnd, input int width);
    return (req * 6 + opnd) * width;
  endfunction

endpackage

// File: rtl/six_adder_scheduler_if.sv
// Requester, adder and result signals of the scheduler; master = environment, slave = scheduler.
interface six_adder_scheduler_if #(
  parameter int N_REQ     = 4,
  parameter int WIDTH_IN  = 45,
  parameter int WIDTH_OUT = 48,
  parameter int TAG_W     = 2
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ*6*WIDTH_IN-1:0] req_data;
  logic [WIDTH_IN-1:0]         add_a, add_b, add_c, add_d, add_e, add_f;
  logic [WIDTH_OUT-1:0]        add_sum;
  logic                        res_valid;
  logic                        res_ready;
  logic [WIDTH_OUT-1:0]        res_sum;
  logic [TAG_W-1:0]            res_tag;
  logic                        busy;

  modport master (
    output req_valid, req_data, add_sum, res_ready,
    input  req_ready, add_a, add_b, add_c, add_d, add_e, add_f,
           res_valid, res_sum, res_tag, busy
  );

  modport slave (
    input  req_valid, req_data, add_sum, res_ready,
    output req_ready, add_a, add_b, add_c, add_d, add_e, add_f,
           res_valid, res_sum, res_tag, busy
  );

endinterface

// File: rtl/six_adder_scheduler_fifo.sv
// Result FIFO holding {tag, sum}; never overflows because every entry is pre-reserved by a credit.
module sched_result_fifo import sched_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [clog2(DEPTH):0] count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             pop_eff;

  assign pop_eff   = pop && (count != '0);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_eff) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_eff})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!reset) !(push && count == FULL));

endmodule

// File: rtl/six_adder_scheduler.sv
// Round-robin scheduler sharing one pipelined six-input adder between N_REQ requesters,
// with a tag pipeline tracking each in-flight sum and a credit-protected result FIFO.
module six_adder_scheduler import sched_pkg::*; #(
  parameter int N_REQ      = 4,
  parameter int WIDTH_IN   = 45,
  parameter int WIDTH_OUT  = 48,
  parameter int ADD_LAT    = ADD_LAT_DEFAULT,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = clog2(N_REQ)
) (
  input logic               clk,
  input logic               reset,
  six_adder_scheduler_if.slave bus
);

  localparam int STAGES = ADD_LAT + 1;
  localparam int CW     = clog2(FIFO_DEPTH) + 1;

  logic [WIDTH_IN-1:0]        ops [N_REQ][6];
  logic [TAG_W-1:0]           ptr, grant_idx, cand;
  logic                       grant;
  logic [N_REQ-1:0]           grant_vec;
  logic [CW-1:0]              credit;
  logic [STAGES-1:0]          stage_valid;
  logic [TAG_W-1:0]           stage_tag [STAGES];
  logic                       pop, fifo_valid;
  logic [TAG_W+WIDTH_OUT-1:0] fifo_data;
  logic [CW-1:0]              fifo_count;

  for (genvar r = 0; r < N_REQ; r++) begin : g_req
    for (genvar k = 0; k < 6; k++) begin : g_op
      assign ops[r][k] = bus.req_data[op_lsb(r, k, WIDTH_IN) +: WIDTH_IN];
    end
  end

  // Without credit there is no FIFO slot to land the sum in, so nobody is granted.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    grant_vec = '0;
    if (credit != '0) begin
      for (int i = 0; i < N_REQ; i++) begin
        cand = TAG_W'((int'(ptr) + i) % N_REQ);
        if (!grant && bus.req_valid[cand]) begin
          grant     = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant) grant_vec[grant_idx] = 1'b1;
  end

  assign bus.req_ready = reset ? grant_vec : '0;
  assign pop           = fifo_valid & bus.res_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      credit      <= CW'(FIFO_DEPTH);
      stage_valid <= '0;
      bus.add_a   <= '0;
      bus.add_b   <= '0;
      bus.add_c   <= '0;
      bus.add_d   <= '0;
      bus.add_e   <= '0;
      bus.add_f   <= '0;
      for (int s = 0; s < STAGES; s++) stage_tag[s] <= '0;
    end else begin
      if (grant) begin
        ptr       <= (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
        bus.add_a <= ops[grant_idx][0];
        bus.add_b <= ops[grant_idx][1];
        bus.add_c <= ops[grant_idx][2];
        bus.add_d <= ops[grant_idx][3];
        bus.add_e <= ops[grant_idx][4];
        bus.add_f <= ops[grant_idx][5];
      end
      stage_valid  <= {stage_valid[STAGES-2:0], grant};
      stage_tag[0] <= grant_idx;
      for (int s = 1; s < STAGES; s++) stage_tag[s] <= stage_tag[s-1];
      case ({grant, pop})
        2'b10:   credit <= credit - CW'(1);
        2'b01:   credit <= credit + CW'(1);
        default: ;
      endcase
    end
  end

  // The last tag stage lines up with add_sum for that issue.
  sched_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TAG_W + WIDTH_OUT)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (stage_valid[STAGES-1]),
    .push_data ({stage_tag[STAGES-1], bus.add_sum}),
    .pop       (pop),
    .out_valid (fifo_valid),
    .out_data  (fifo_data),
    .count     (fifo_count)
  );

  assign bus.res_valid = fifo_valid;
  assign bus.res_sum   = fifo_data[WIDTH_OUT-1:0];
  assign bus.res_tag   = fifo_data[TAG_W+WIDTH_OUT-1:WIDTH_OUT];
  assign bus.busy      = (|stage_valid) | fifo_valid;

  assert property (@(posedge clk) disable iff (!reset)
    int'(credit) + $countones(stage_valid) + int'(fifo_count) == FIFO_DEPTH);

endmodule

// File: tb/tb_six_adder_scheduler.sv
// Bench for six_adder_scheduler: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_six_adder_scheduler;
  import sched_pkg::*;

  localparam int N_REQ      = 4;
  localparam int WIDTH_IN   = 45;
  localparam int WIDTH_OUT  = 48;
  localparam int ADD_LAT    = ADD_LAT_DEFAULT;
  localparam int FIFO_DEPTH = 8;
  localparam int TAG_W      = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  six_adder_scheduler_if #(.N_REQ(N_REQ), .WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT), .TAG_W(TAG_W)) bus ();

  six_adder_scheduler #(
    .N_REQ(N_REQ), .WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT),
    .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the external adder: signed sum of the registered operands, ADD_LAT stages deep.
  logic [WIDTH_OUT-1:0] adder_pipe [ADD_LAT];
  always @(posedge clk) begin
    adder_pipe[0] <= WIDTH_OUT'($signed(bus.add_a)) + WIDTH_OUT'($signed(bus.add_b)) +
                     WIDTH_OUT'($signed(bus.add_c)) + WIDTH_OUT'($signed(bus.add_d)) +
                     WIDTH_OUT'($signed(bus.add_e)) + WIDTH_OUT'($signed(bus.add_f));
    for (int i = 1; i < ADD_LAT; i++) adder_pipe[i] <= adder_pipe[i-1];
  end
  assign bus.add_sum = adder_pipe[ADD_LAT-1];

  typedef struct { int tag; logic [WIDTH_OUT-1:0] sum; int left; } flight_t;
  typedef struct { int tag; logic [WIDTH_OUT-1:0] sum; } result_t;

  flight_t             m_flight[$];
  result_t             m_fifo[$];
  logic [WIDTH_IN-1:0] m_ops [6];
  int                  m_ptr;
  int                  cyc, checks, errors;

  logic [N_REQ-1:0]     seen_ready;
  logic                 seen_valid;
  logic [WIDTH_OUT-1:0] seen_sum;
  int                   seen_tag;

  task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_flight.delete();
    m_fifo.delete();
    m_ptr = 0;
    for (int k = 0; k < 6; k++) m_ops[k] = '0;
  endtask

  task automatic set_op(input int r, input int k, input logic [WIDTH_IN-1:0] val);
    bus.req_data[(r*6+k)*WIDTH_IN +: WIDTH_IN] = val;
  endtask

  task automatic rand_data();
    for (int r = 0; r < N_REQ; r++)
      for (int k = 0; k < 6; k++) set_op(r, k, WIDTH_IN'({$urandom(), $urandom()}));
  endtask

  function automatic logic [WIDTH_IN-1:0] op_of(input int r, input int k);
    return bus.req_data[(r*6+k)*WIDTH_IN +: WIDTH_IN];
  endfunction

  function automatic logic [WIDTH_OUT-1:0] ref_sum(input int r);
    longint s;
    logic [WIDTH_IN-1:0] v;
    s = 0;
    for (int k = 0; k < 6; k++) begin
      v = op_of(r, k);
      s += longint'($signed(v));
    end
    return s[WIDTH_OUT-1:0];
  endfunction

  task automatic applyStimulus(input logic [N_REQ-1:0] valid, input logic ready);
    bus.req_valid = valid;
    bus.res_ready = ready;
  endtask

  // Compare one cycle against the model, then advance the model across the next rising edge.
  task automatic checkOutput();
    int                   g, credit, r;
    logic [N_REQ-1:0]     exp_ready;
    logic [WIDTH_IN-1:0]  act_ops [6];
    logic [WIDTH_IN-1:0]  new_ops [6];
    logic [WIDTH_OUT-1:0] new_sum;
    logic                 do_pop;
    flight_t              f;
    result_t              res;
    #1;
    credit = FIFO_DEPTH - m_flight.size() - m_fifo.size();
    g = -1;
    if (credit > 0)
      for (int i = 0; i < N_REQ; i++) begin
        r = (m_ptr + i) % N_REQ;
        if (g < 0 && bus.req_valid[TAG_W'(r)]) g = r;
      end
    exp_ready = '0;
    if (g >= 0) exp_ready[TAG_W'(g)] = 1'b1;
    seen_ready = bus.req_ready;
    seen_valid = bus.res_valid;
    seen_sum   = bus.res_sum;
    seen_tag   = int'(bus.res_tag);
    expect_eq("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    expect_eq("res_valid", 64'(bus.res_valid), 64'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      expect_eq("res_sum", 64'(bus.res_sum), 64'(m_fifo[0].sum));
      expect_eq("res_tag", 64'(bus.res_tag), 64'(m_fifo[0].tag));
    end
    expect_eq("busy", 64'(bus.busy), 64'(m_flight.size() != 0 || m_fifo.size() != 0));
    act_ops = '{bus.add_a, bus.add_b, bus.add_c, bus.add_d, bus.add_e, bus.add_f};
    for (int k = 0; k < 6; k++) expect_eq("add_operand", 64'(act_ops[k]), 64'(m_ops[k]));
    do_pop  = (m_fifo.size() != 0) && bus.res_ready;
    new_sum = '0;
    for (int k = 0; k < 6; k++) new_ops[k] = '0;
    if (g >= 0) begin
      new_sum = ref_sum(g);
      for (int k = 0; k < 6; k++) new_ops[k] = op_of(g, k);
    end
    @(posedge clk);
    if (do_pop) void'(m_fifo.pop_front());
    foreach (m_flight[i]) m_flight[i].left--;
    while (m_flight.size() != 0 && m_flight[0].left == 0) begin
      res.tag = m_flight[0].tag;
      res.sum = m_flight[0].sum;
      m_fifo.push_back(res);
      void'(m_flight.pop_front());
    end
    if (g >= 0) begin
      f.tag = g; f.sum = new_sum; f.left = ADD_LAT + 1;
      m_flight.push_back(f);
      m_ops = new_ops;
      m_ptr = (g + 1) % N_REQ;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    expect_eq("rst_req_ready", 64'(bus.req_ready), 64'(0));
    expect_eq("rst_res_valid", 64'(bus.res_valid), 64'(0));
    expect_eq("rst_res_sum",   64'(bus.res_sum),   64'(0));
    expect_eq("rst_res_tag",   64'(bus.res_tag),   64'(0));
    expect_eq("rst_busy",      64'(bus.busy),      64'(0));
    expect_eq("rst_add_a",     64'(bus.add_a),     64'(0));
    expect_eq("rst_add_f",     64'(bus.add_f),     64'(0));
  endtask

  task automatic wait_result(input string name, input int grant_cycle, input logic [WIDTH_OUT-1:0] want_sum);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      checkOutput();
      if (seen_valid) begin
        found = 1'b1;
        expect_eq({name, "_latency"}, 64'(cyc - 1 - grant_cycle - 1), 64'(4));
        expect_eq({name, "_sum"}, 64'(seen_sum), 64'(want_sum));
        expect_eq({name, "_tag"}, 64'(seen_tag), 64'(0));
      end
    end
    expect_eq({name, "_seen"}, 64'(found), 64'(1));
  endtask

  task automatic count_grants(input int n, output int grants);
    grants = 0;
    repeat (n) begin
      checkOutput();
      grants += $countones(seen_ready);
    end
  endtask

  initial begin
    int grant_cycle, grants;
    logic [N_REQ-1:0] order [8];
    checks = 0; errors = 0; cyc = 0;
    order = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req_data = '0;
    applyStimulus(4'b1111, 1'b0);
    model_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] single request, operands 1..6");
    for (int k = 0; k < 6; k++) set_op(0, k, WIDTH_IN'(k + 1));
    applyStimulus(4'b0001, 1'b1);
    checkOutput();
    grant_cycle = cyc - 1;
    expect_eq("t1_grant", 64'(seen_ready), 64'(4'b0001));
    applyStimulus(4'b0000, 1'b1);
    wait_result("t1", grant_cycle, 48'd21);

    $display("[TB] negative operand");
    set_op(0, 0, {WIDTH_IN{1'b1}});
    for (int k = 1; k < 6; k++) set_op(0, k, '0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput();
    grant_cycle = cyc - 1;
    applyStimulus(4'b0000, 1'b1);
    wait_result("t6", grant_cycle, 48'hFFFF_FFFF_FFFF);

    $display("[TB] all requesters, round-robin order");
    rand_data();
    applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput();
      expect_eq("t2_order", 64'(seen_ready), 64'(order[i]));
    end
    applyStimulus(4'b0000, 1'b1);
    repeat (12) checkOutput();

    $display("[TB] credit exhaustion with res_ready low");
    applyStimulus(4'b1111, 1'b0);
    count_grants(16, grants);
    expect_eq("t3_grants_full", 64'(grants), 64'(8));
    applyStimulus(4'b0000, 1'b1);
    repeat (3) checkOutput();
    applyStimulus(4'b1111, 1'b0);
    count_grants(12, grants);
    expect_eq("t3_grants_after_pops", 64'(grants), 64'(3));

    $display("[TB] grant and pop together at credit 1");
    applyStimulus(4'b1111, 1'b1);
    count_grants(1, grants);
    expect_eq("t4_no_credit", 64'(grants), 64'(0));
    count_grants(1, grants);
    expect_eq("t4_grant_with_pop", 64'(grants), 64'(1));
    count_grants(1, grants);
    expect_eq("t4_grant_again", 64'(grants), 64'(1));
    applyStimulus(4'b0000, 1'b1);
    repeat (16) checkOutput();

    $display("[TB] reset with sums in flight and queued");
    rand_data();
    applyStimulus(4'b1111, 1'b0);
    repeat (2) checkOutput();
    applyStimulus(4'b0000, 1'b0);
    repeat (5) checkOutput();
    applyStimulus(4'b1111, 1'b0);
    repeat (3) checkOutput();
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    rand_data();
    applyStimulus(4'b1111, 1'b0);
    count_grants(20, grants);
    expect_eq("t5_credit_after_reset", 64'(grants), 64'(8));
    applyStimulus(4'b0000, 1'b1);
    repeat (12) checkOutput();

    $display("[TB] randomized traffic");
    repeat (400) begin
      rand_data();
      applyStimulus(N_REQ'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      checkOutput();
    end
    applyStimulus(4'b0000, 1'b1);
    repeat (20) checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/six_adder_scheduler.md
Name: six_adder_scheduler

Overview:
- Shares one six_input_adder pipeline between N_REQ requesters, e.g. per-channel window tap groups of the spatial filter.
- Each cycle it picks at most one requester by round-robin, registers that requester's six operands onto the adder inputs, and tracks ownership of every in-flight sum with a tag pipeline.
- Completed sums land in a credit-protected result FIFO with a valid/ready output, because the adder pipeline cannot stall.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH_IN, 45, operand width; matches the adder's WIDTH_IN.
- WIDTH_OUT, 48, sum width; matches the adder's WIDTH_OUT.
- ADD_LAT, 3, clock cycles from adder operand inputs to a valid SUM.
- FIFO_DEPTH, 8, result FIFO entries; power of 2, at least 2.
- TAG_W, clog2(N_REQ), width of the requester index.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; the clock is clk.
- req_valid  in  N_REQ  per-requester operand set valid.
- req_data  in  N_REQ*6*WIDTH_IN  packed operands; requester r occupies slice r, operand order A..F, A in the low bits.
- req_ready  out  N_REQ  one-hot grant; a transfer happens when req_valid[r] and req_ready[r] are both high.
- add_a, add_b, add_c, add_d, add_e, add_f  out  WIDTH_IN each  registered adder operands.
- add_sum  in  WIDTH_OUT  adder SUM.
- res_valid  out  1  result FIFO not empty.
- res_ready  in  1  downstream accepts the result.
- res_sum  out  WIDTH_OUT  head-of-FIFO sum.
- res_tag  out  TAG_W  requester index owning res_sum.
- busy  out  1  an issue is in flight or the FIFO is not empty.

Behaviour:
- Reset (asynchronous assert, synchronous release) clears:
  - all req_ready bits, the add_* outputs, res_valid, res_sum, res_tag and busy to 0;
  - the round-robin pointer to 0;
  - the FIFO read/write pointers;
  - the valid/tag pipeline;
  - credit to FIFO_DEPTH.
- Reset asserted mid-operation drops every in-flight sum. No result from before reset ever appears afterwards.
- Credit: one FIFO slot is reserved per issue.
  - Credit is decremented on a grant and incremented on a FIFO pop (res_valid and res_ready both high).
  - A grant and a pop in the same cycle leave credit unchanged.
  - The invariant credit + in-flight + FIFO occupancy = FIFO_DEPTH must always hold.
- Arbitration (combinational, same cycle):
  - If credit is 0, req_ready is all zeros.
  - Otherwise grant the first r with req_valid[r] high, searching r = ptr, ptr+1, ... modulo N_REQ.
  - After a grant, ptr becomes granted index + 1, wrapping from N_REQ-1 to 0. With no grant, ptr holds.
- req_ready may depend on req_valid. Requesters must not make valid depend on ready.
- Issue stage: on a grant, the operands are registered onto add_a..add_f at the next edge. With no grant, add_* hold their previous values (no toggling).
- Tracking pipeline:
  - An (issue valid, tag) shift register of ADD_LAT+1 stages, starting at the grant edge.
  - Its final stage coincides with add_sum being valid for that issue.
  - Latency from the grant cycle to the FIFO write is exactly ADD_LAT+1 cycles.
  - The FIFO write stores {tag, add_sum}.
- FIFO:
  - Registered output. res_valid is high whenever occupancy is non-zero.
  - A simultaneous push and pop are both performed.
  - Push-when-full is impossible by the credit rule; simulation asserts flag it.
  - Pop when empty is ignored.
- Throughput:
  - One issue per cycle sustained while credit is non-zero.
  - The full rate holds when res_ready stays high and FIFO_DEPTH >= ADD_LAT+2.
- busy = any valid pipeline stage or FIFO occupancy not 0 or issue register valid.
- Arithmetic is done entirely by the adder; the scheduler never modifies data widths.

Decomposition:
- Shared package sched_pkg holds:
  - the clog2 function;
  - the operand-slice index helper (offset for requester r, operand k);
  - the adder latency constant ADD_LAT_DEFAULT = 3, used by the top level and bench.
- One natural sub-module: sched_result_fifo (depth FIFO_DEPTH, width TAG_W+WIDTH_OUT, registered output, push/pop/count).
- The arbiter, issue register and tag pipeline stay in the top level.

Test Plan:
1. Single request: req_valid=0001 with operands 1,2,3,4,5,6 and a behavioural adder model of ADD_LAT=3 -> req_ready=0001 in the same cycle; res_valid rises 4 cycles after the grant with res_sum=21 and res_tag=0.
2. All four requesters valid continuously, res_ready=1 -> grant order 0,1,2,3,0,1,...; one grant per cycle; the res_tag sequence matches the grant order.
3. res_ready held at 0 with all requesters valid -> exactly 8 grants, then req_ready=0; after 3 pops, exactly 3 more grants follow; no FIFO overflow assertion fires.
4. Simultaneous grant and pop while credit is 1 -> credit stays 1 and the next cycle grants again.
5. Reset pulsed low with 3 sums in flight and 2 queued -> all outputs go to 0 asynchronously; after release no stale result appears and credit reads 8.
6. Negative operands (A=-1, others 0; WIDTH_IN=45) -> res_sum = 48'hFFFF_FFFF_FFFF, confirming sign handling passes through unchanged.
